sync_counter_checker: RTL and testbench

SYNC_COUNTER_CHECKER -- requirements
Module: sync_counter_checker

---
 rtl/sync_counter_checker.sv | 102 ++++++++++
 tb/tb_sync_counter_checker.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sync_counter_checker.sv
// sync_counter_checker: tracks an external up/down counter, locks after LOCK_N
// correct predictions and flags sequence errors and correct wrap-arounds.
module sync_counter_checker #(
    parameter int SIZE   = 4,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [SIZE-1:0]  count,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic [SIZE-1:0]  expected
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [SIZE-1:0]  ONE     = SIZE'(1);
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
    localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);

    state_t           r_state;
    logic [3:0]       r_match;
    logic             r_dir;
    logic             r_locked;
    logic             r_err;
    logic             r_wrap;
    logic [ERR_W-1:0] r_err_count;
    logic [SIZE-1:0]  r_expected;

    logic             w_hit;
    logic             w_wrap_hit;
    logic [3:0]       w_match_inc;
    logic [SIZE-1:0]  w_next;
    logic [ERR_W-1:0] w_err_next;

    assign w_hit       = count == r_expected;
    assign w_next      = up ? count + ONE : count - ONE;
    assign w_match_inc = r_match + 4'd1;
    // r_dir is the direction the current prediction was made with
    assign w_wrap_hit  = r_dir ? (count == '0) : (count == '1);
    assign w_err_next  = &r_err_count ? r_err_count : r_err_count + ERR_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_match     <= '0;
            r_dir       <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_wrap      <= 1'b0;
            r_err_count <= '0;
            r_expected  <= '0;
        end else begin
            r_err  <= 1'b0;
            r_wrap <= 1'b0;
            if (en) begin
                r_expected <= w_next;
                r_dir      <= up;
                case (r_state)
                    IDLE: begin
                        r_state <= ACQUIRE;
                        r_match <= '0;
                    end
                    ACQUIRE: begin
                        if (w_hit && w_match_inc == LOCK_V) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                            r_match  <= '0;
                        end else begin
                            r_match <= w_hit ? w_match_inc : 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (w_hit) begin
                            r_wrap <= w_wrap_hit;
                        end else begin
                            r_err       <= 1'b1;
                            r_state     <= ACQUIRE;
                            r_locked    <= 1'b0;
                            r_match     <= '0;
                            r_err_count <= w_err_next;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
            // clear wins over a same-cycle increment
            if (clr_err) r_err_count <= '0;
        end
    end

    assign locked    = r_locked;
    assign err       = r_err;
    assign wrap      = r_wrap;
    assign err_count = r_err_count;
    assign expected  = r_expected;
endmodule

// File: tb/tb_sync_counter_checker.sv
// tb_sync_counter_checker: vector table plus hand sequences for saturation,
// clear priority, asynchronous reset and direction change.
module tb_sync_counter_checker;
    typedef struct {
        logic       en;
        logic       up;
        logic [3:0] cnt;
        logic       lk;
        logic       er;
        logic       wr;
        logic [1:0] ec;
        logic [3:0] ex;
    } vec_t;

    typedef struct {
        logic       lk;
        logic       er;
        logic       wr;
        logic [1:0] ec;
        logic [3:0] ex;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic [3:0] count = '0;
    logic       clr_err = 1'b0;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [1:0] err_count;
    logic [3:0] expected;

    int checks = 0;
    int errors = 0;
    vec_t vt[$];
    out_t sb_q[$];
    logic [3:0] m_ex;
    logic [1:0] m_ec;

    sync_counter_checker #(.SIZE(4), .LOCK_N(2), .ERR_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .count(count), .clr_err(clr_err),
        .locked(locked), .err(err), .wrap(wrap), .err_count(err_count), .expected(expected)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input out_t o);
        cmp({tag, " locked"}, {7'd0, locked}, {7'd0, o.lk});
        cmp({tag, " err"}, {7'd0, err}, {7'd0, o.er});
        cmp({tag, " wrap"}, {7'd0, wrap}, {7'd0, o.wr});
        cmp({tag, " err_count"}, {6'd0, err_count}, {6'd0, o.ec});
        cmp({tag, " expected"}, {4'd0, expected}, {4'd0, o.ex});
    endtask

    task automatic step(input string tag, input logic e, input logic u, input logic [3:0] c,
                        input logic clr, input logic lk, input logic er, input logic wr,
                        input logic [1:0] ec, input logic [3:0] ex);
        out_t o;
        en = e; up = u; count = c; clr_err = clr;
        sb_q.push_back('{lk, er, wr, ec, ex});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            o = sb_q.pop_front();
            check_all(tag, o);
        end
    endtask

    task automatic add(input logic e, input logic u, input logic [3:0] c, input logic lk,
                       input logic er, input logic wr, input logic [1:0] ec, input logic [3:0] ex);
        vt.push_back('{e, u, c, lk, er, wr, ec, ex});
    endtask

    // mismatch while locked, then two correct samples to relock
    task automatic mis_relock(input string tag, input logic clr);
        logic [3:0] b;
        b = m_ex + 4'd5;
        m_ec = clr ? 2'd0 : (m_ec == 2'd3 ? 2'd3 : m_ec + 2'd1);
        step({tag, " miss"}, 1, 1, b, clr, 0, 1, 0, m_ec, b + 4'd1);
        step({tag, " acq"}, 1, 1, b + 4'd1, 0, 0, 0, 0, m_ec, b + 4'd2);
        step({tag, " relock"}, 1, 1, b + 4'd2, 0, 1, 0, 0, m_ec, b + 4'd3);
        m_ex = b + 4'd3;
    endtask

    initial begin
        add(1, 1, 3,  0, 0, 0, 0, 4);
        add(1, 1, 4,  0, 0, 0, 0, 5);
        add(1, 1, 5,  1, 0, 0, 0, 6);
        add(0, 1, 9,  1, 0, 0, 0, 6);
        add(1, 1, 6,  1, 0, 0, 0, 7);
        add(1, 1, 7,  1, 0, 0, 0, 8);
        add(1, 1, 9,  0, 1, 0, 1, 10);
        add(1, 1, 10, 0, 0, 0, 1, 11);
        add(1, 1, 13, 0, 0, 0, 1, 14);
        add(1, 1, 14, 0, 0, 0, 1, 15);
        add(1, 1, 15, 1, 0, 0, 1, 0);
        add(1, 1, 0,  1, 0, 1, 1, 1);
        add(1, 0, 1,  1, 0, 0, 1, 0);
        add(1, 0, 0,  1, 0, 0, 1, 15);
        add(1, 0, 15, 1, 0, 1, 1, 14);
        add(0, 0, 15, 1, 0, 0, 1, 14);
        add(1, 1, 14, 1, 0, 0, 1, 15);
        add(1, 0, 15, 1, 0, 0, 1, 14);
        add(1, 0, 14, 1, 0, 0, 1, 13);
        add(1, 1, 13, 1, 0, 0, 1, 14);

        @(posedge clk);
        #1;
        check_all("reset", '{0, 0, 0, 2'd0, 4'd0});
        rst = 1'b1;
        foreach (vt[i])
            step($sformatf("vec%0d", i), vt[i].en, vt[i].up, vt[i].cnt, 0,
                 vt[i].lk, vt[i].er, vt[i].wr, vt[i].ec, vt[i].ex);

        m_ex = 4'd14;
        m_ec = 2'd1;
        for (int i = 0; i < 4; i++) mis_relock($sformatf("sat%0d", i), 0);
        mis_relock("clr", 1);
        mis_relock("pre_rst0", 0);
        mis_relock("pre_rst1", 0);

        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", '{0, 0, 0, 2'd0, 4'd0});
        en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        step("post_rst idle", 0, 1, 7, 0, 0, 0, 0, 0, 0);
        step("restart", 1, 1, 2, 0, 0, 0, 0, 0, 3);
        step("restart m1", 1, 1, 3, 0, 0, 0, 0, 0, 4);
        step("restart lock", 1, 1, 4, 0, 1, 0, 0, 0, 5);
        step("dir 5up", 1, 1, 5, 0, 1, 0, 0, 0, 6);
        step("dir 6dn", 1, 0, 6, 0, 1, 0, 0, 0, 5);
        step("dir 5dn", 1, 0, 5, 0, 1, 0, 0, 0, 4);
        step("dir 4dn", 1, 0, 4, 0, 1, 0, 0, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
